// File: rtl/sample_capture.sv
// Trigger-aligned circular sample buffer for the scope capture path.
// Optional hysteresis re-arm on the edge trigger: define SAMPLE_CAPTURE_HYST_EN.
module sample_capture #(
    parameter int DEPTH_LOG2 = 8,
    parameter int PRETRIG    = 64,
    parameter int HYST       = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            sample_in,
    input  logic                  sample_valid,
    input  logic                  arm,
    input  logic [7:0]            trig_level,
    input  logic                  trig_falling,
    input  logic                  force_trig,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output logic [7:0]            rd_data,
    output logic                  busy,
    output logic                  done
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int POST  = DEPTH - PRETRIG - 1;

    typedef logic [DEPTH_LOG2-1:0] ptr_t;

    localparam ptr_t PRE_P     = ptr_t'(PRETRIG);
    localparam ptr_t PRE_LAST  = ptr_t'(PRETRIG - 1);
    localparam ptr_t POST_LAST = ptr_t'(POST - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREFILL,
        S_WAIT_TRIG,
        S_POSTFILL,
        S_DONE
    } state_t;

    state_t     state_q, state_d;
    ptr_t       wr_ptr_q, wr_ptr_d;
    ptr_t       count_q, count_d;
    ptr_t       trig_ptr_q, trig_ptr_d;
    logic [7:0] prev_q, prev_d;
    logic       prev_vld_q, prev_vld_d;
    logic       done_q, done_d;
    logic [7:0] rd_data_q, rd_data_d;

    logic [7:0] mem [DEPTH];

    logic       capturing;
    logic       wr_en;
    logic       rise_edge;
    logic       fall_edge;
    logic       edge_hit;
    logic       trig_hit;
    ptr_t       rd_phys;

`ifdef SAMPLE_CAPTURE_HYST_EN
    logic       hyst_arm_q, hyst_arm_d;
    logic [8:0] lo_diff;
    logic [8:0] hi_sum;
    logic [7:0] lo_thr;
    logic [7:0] hi_thr;
    logic       rearm_hit;
`endif

    assign capturing = (state_q == S_PREFILL) || (state_q == S_WAIT_TRIG) ||
                       (state_q == S_POSTFILL);

    // Edge detection always compares against the previous accepted sample, not the previous cycle.
    assign rise_edge = prev_vld_q && (prev_q < trig_level) && (sample_in >= trig_level);
    assign fall_edge = prev_vld_q && (prev_q > trig_level) && (sample_in <= trig_level);
    assign edge_hit  = trig_falling ? fall_edge : rise_edge;

`ifdef SAMPLE_CAPTURE_HYST_EN
    assign lo_diff   = {1'b0, trig_level} - 9'(HYST);
    assign hi_sum    = {1'b0, trig_level} + 9'(HYST);
    assign lo_thr    = lo_diff[8] ? 8'h00 : lo_diff[7:0];
    assign hi_thr    = hi_sum[8] ? 8'hFF : hi_sum[7:0];
    assign rearm_hit = trig_falling ? (sample_in >= hi_thr) : (sample_in <= lo_thr);
    assign trig_hit  = force_trig || (edge_hit && hyst_arm_q);
`else
    assign trig_hit  = force_trig || edge_hit;
`endif

    // Logical index 0 is the oldest pre-trigger sample; wraps naturally in DEPTH_LOG2 bits.
    assign rd_phys = trig_ptr_q - PRE_P + rd_addr;

    always_comb begin
        // NOTE: every variable gets a default first so no path through the case infers a latch.
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        trig_ptr_d = trig_ptr_q;
        prev_d     = prev_q;
        prev_vld_d = prev_vld_q;
        wr_en      = 1'b0;
        rd_data_d  = mem[rd_phys];
`ifdef SAMPLE_CAPTURE_HYST_EN
        hyst_arm_d = hyst_arm_q;
`endif

        if (arm) begin
            state_d    = S_PREFILL;
            wr_ptr_d   = '0;
            count_d    = '0;
            prev_vld_d = 1'b0;
`ifdef SAMPLE_CAPTURE_HYST_EN
            hyst_arm_d = 1'b0;
`endif
        end else if (capturing && sample_valid) begin
            wr_en      = 1'b1;
            wr_ptr_d   = wr_ptr_q + 1'b1;
            prev_d     = sample_in;
            prev_vld_d = 1'b1;
            case (state_q)
                S_PREFILL: begin
                    if (count_q == PRE_LAST) begin
                        state_d = S_WAIT_TRIG;
                        count_d = '0;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
                S_WAIT_TRIG: begin
                    if (trig_hit) begin
                        trig_ptr_d = wr_ptr_q;
                        count_d    = '0;
                        state_d    = (POST == 0) ? S_DONE : S_POSTFILL;
                    end
`ifdef SAMPLE_CAPTURE_HYST_EN
                    else if (rearm_hit) begin
                        hyst_arm_d = 1'b1;
                    end
`endif
                end
                S_POSTFILL: begin
                    if (count_q == POST_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end

        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            trig_ptr_q <= '0;
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
            done_q     <= 1'b0;
            rd_data_q  <= '0;
`ifdef SAMPLE_CAPTURE_HYST_EN
            hyst_arm_q <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge value of its peers.
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            trig_ptr_q <= trig_ptr_d;
            prev_q     <= prev_d;
            prev_vld_q <= prev_vld_d;
            done_q     <= done_d;
            rd_data_q  <= rd_data_d;
`ifdef SAMPLE_CAPTURE_HYST_EN
            hyst_arm_q <= hyst_arm_d;
`endif
        end
    end

    // NOTE: the sample store has no reset; contents are only meaningful once a capture completes.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= sample_in;
        end
    end

    assign busy    = capturing;
    assign done    = done_q;
    assign rd_data = rd_data_q;

endmodule
